// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared state encoding and defaults for the pipeline skid bank.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam int BUS_WIDTH_DEFAULT = 32;

    typedef logic [1:0] state_t;

    // State value doubles as the occupancy count
    localparam state_t ST_EMPTY = 2'd0;
    localparam state_t ST_ONE   = 2'd1;
    localparam state_t ST_TWO   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/register.sv
`default_nettype none
// ============================================================================
// Module      : register
// Description : N-bit load-enable register, asynchronous active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
module register #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (ena) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_skid_bank.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_skid_bank
// Description : NUM_CH-lane pipeline stage with valid/ready handshake,
//               one-entry skid buffer and synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_skid_bank
    import pipeline_pkg::*;
#(
    parameter int BUS_WIDTH = BUS_WIDTH_DEFAULT,
    parameter int NUM_CH    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_CH*BUS_WIDTH-1:0] d,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_CH*BUS_WIDTH-1:0] q,
    output logic [1:0]                  occupancy
);

    localparam int c_width = NUM_CH * BUS_WIDTH;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_consume;
    logic               w_main_load;
    logic               w_main_from_skid;
    logic               w_skid_load;
    logic [c_width-1:0] w_main_d;
    logic [c_width-1:0] w_main_q;
    logic [c_width-1:0] w_skid_q;

    // Ready decodes the state register only, never out_ready
    assign in_ready  = (r_state != ST_TWO);
    assign out_valid = (r_state != ST_EMPTY);
    assign occupancy = r_state;
    assign w_accept  = in_valid & in_ready;
    assign w_consume = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_main_load  = 1'b1;
                    w_state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && w_consume) begin
                    w_main_load = 1'b1;
                end else if (w_accept) begin
                    w_skid_load  = 1'b1;
                    w_state_next = ST_TWO;
                end else if (w_consume) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_consume) begin
                    w_main_load      = 1'b1;
                    w_main_from_skid = 1'b1;
                    w_state_next     = ST_ONE;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
        // Flush discards everything, including a beat handed over this cycle;
        // slot contents are left untouched so q holds its last value.
        if (flush) begin
            w_state_next     = ST_EMPTY;
            w_main_load      = 1'b0;
            w_main_from_skid = 1'b0;
            w_skid_load      = 1'b0;
        end
    end

    assign w_main_d = w_main_from_skid ? w_skid_q : d;

    register #(
        .N (c_width)
    ) u_main (
        .clk (clk),
        .rst (rst),
        .ena (w_main_load),
        .d   (w_main_d),
        .q   (w_main_q)
    );

    register #(
        .N (c_width)
    ) u_skid (
        .clk (clk),
        .rst (rst),
        .ena (w_skid_load),
        .d   (d),
        .q   (w_skid_q)
    );

    assign q = w_main_q;

endmodule
`default_nettype wire

// File: doc/pipeline_skid_bank.md
# pipeline_skid_bank

- Parametrised successor to the two-channel pipeline latch.
- Carries NUM_CH operand channels of BUS_WIDTH bits each between pipeline stages.
- Adds a valid/ready handshake and a one-entry skid buffer, so back-pressure from the downstream stage never drops data and never costs a bubble.
- Synchronous flush squashes in-flight contents on branch redirect.

## Interface
- BUS_WIDTH, 32, width of one channel
- NUM_CH, 2, number of channels carried in lockstep (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream presents a beat on d
- in_ready  out  1  bank can accept a beat this cycle
- d  in  NUM_CH*BUS_WIDTH  packed input channels; channel k at bits [k*BUS_WIDTH +: BUS_WIDTH]
- out_valid  out  1  q holds a valid beat
- out_ready  in  1  downstream consumes q this cycle
- q  out  NUM_CH*BUS_WIDTH  packed output channels, same packing as d
- occupancy  out  2  number of held beats (0, 1 or 2)

## Operation
- Two storage slots, each NUM_CH*BUS_WIDTH wide:
  - MAIN drives q.
  - SKID catches a beat accepted while MAIN is stalled.
- States (occupancy): EMPTY (0), ONE (1, MAIN only), TWO (MAIN + SKID).
- Handshakes: accept = in_valid & in_ready; consume = out_valid & out_ready.
- Transitions:
  - EMPTY: accept → MAIN←d, ONE.
  - ONE:
    - accept & consume → MAIN←d, stay ONE.
    - accept & !consume → SKID←d, TWO.
    - consume & !accept → EMPTY.
    - neither → hold.
  - TWO: consume → MAIN←SKID, ONE; otherwise hold. No accept is possible because in_ready=0.
- Outputs:
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO). in_ready is a registered function of state and never combinationally depends on out_ready.
  - occupancy is the state encoding.
- flush:
  - Next state is EMPTY regardless of accept or consume in the same cycle.
  - A beat accepted in a flush cycle is discarded.
  - Slot data is not cleared; q keeps its last value but out_valid=0.
- Data ordering is strict FIFO. Channels never reorder or split; all NUM_CH lanes move together.
- Slot registers load only on the transitions above, so unrelated cycles do not toggle them.

## Timing
- Reset (rst=0, asynchronous): state=EMPTY, out_valid=0, in_ready=1, occupancy=0, q=0, SKID=0. All take effect immediately, with no clock required.
- Reset deassertion is synchronised externally. The first accept can occur on the first clk edge with rst=1.
- Latency: a beat accepted at edge N is on q with out_valid=1 after edge N, i.e. visible in cycle N+1.
- Throughput: one beat per cycle sustained while out_ready=1.
- Back-pressure: after out_ready falls, at most one further beat is accepted, into SKID. in_ready falls the cycle after SKID fills.
- Release: in TWO, a consume makes in_ready=1 in the next cycle. SKID data reaches q on the same edge.
- Flush: out_valid=0 and in_ready=1 in the cycle after the flush edge.
- Reset asserted mid-transfer: all held beats are lost with no handshake completion; upstream re-sends.

## Structure
- Shared package pipeline_pkg:
  - State localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
  - Default BUS_WIDTH.
- Sub-module: the team's existing parametrised `register` is the storage primitive, instantiated twice (MAIN, SKID) with N=NUM_CH*BUS_WIDTH.
  - The `register` primitive must support active-low asynchronous reset.
  - Each instance's ena is driven by the FSM load strobes.
- FSM, handshake logic and MAIN/SKID mux live in pipeline_skid_bank itself.

## Test plan
- Reset:
  - Stimulus: assert rst=0 mid-cycle while in state TWO.
  - Response: out_valid=0, in_ready=1, occupancy=0 and q=0 immediately, with no clock edge.
- Streaming:
  - Stimulus: NUM_CH=2, out_ready=1, in_valid=1 for 8 cycles with d={k,k+100}, k=1..8.
  - Response: q shows {1,101}…{8,108} on consecutive cycles, 1-cycle latency, in_ready never 0.
- Stall:
  - Stimulus: out_ready=0 while streaming 0xA, 0xB, 0xC.
  - Response: occupancy goes to 2 and in_ready=0; 0xC is held by upstream.
  - Stimulus: out_ready=1.
  - Response: q=0xA then 0xB then 0xC in order.
- Simultaneous accept and consume in ONE:
  - Response: occupancy stays 1 and q updates to the new beat each cycle.
- Flush:
  - Stimulus: flush=1 in TWO with in_valid=1, d=0x55.
  - Response: next cycle out_valid=0, occupancy=0, and 0x55 is never emitted.
- Width sweep:
  - Stimulus: BUS_WIDTH=8, NUM_CH=4; random valid/ready for 10k cycles.
  - Response: scoreboard shows no loss, duplication or lane swap, and in_ready never depends combinationally on out_ready.
